// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if: control, compare and status signals between board-level
// control logic (master) and the counter run controller (slave).
// Handshake: there is no valid/ready pair. Every control input is a level
// sampled on each rising clock edge. cnt_count_o, cnt_clear_o, wrap_o and
// done_o are valid for exactly the cycle in which they are high.
interface counter_ctrl_if #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 16
) ();
  logic                  start_i;
  logic                  stop_i;
  logic                  step_i;
  logic                  mode_i;
  logic [WIDTH-1:0]      limit_i;
  logic [PRESCALE_W-1:0] prescale_i;
  logic [WIDTH-1:0]      q_i;
  logic                  cnt_count_o;
  logic                  cnt_clear_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  wrap_o;
  logic [1:0]            state_o;

  // Controller side.
  modport slave (
    input  start_i, stop_i, step_i, mode_i, limit_i, prescale_i, q_i,
    output cnt_count_o, cnt_clear_o, busy_o, done_o, wrap_o, state_o
  );

  // Board-control side.
  modport master (
    output start_i, stop_i, step_i, mode_i, limit_i, prescale_i, q_i,
    input  cnt_count_o, cnt_clear_o, busy_o, done_o, wrap_o, state_o
  );
endinterface

// File: rtl/counter_ctrl.sv
// counter_ctrl: run controller for the counter datapath. It drives the
// counter's count/clear inputs and supports start/stop/single-step,
// terminal-value compare and free-run-wrap or one-shot modes.
// Optional feature macro: COUNTER_CTRL_PRESCALE_EN adds a programmable tick
// prescaler. Without it, every RUN cycle that has no stop is a tick.
module counter_ctrl #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic            clock_i,
  input  logic            clear_i,
  counter_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic tick;        // one counter tick resolves this cycle
  logic reload;      // load the prescaler from prescale_i
  logic run_adv;     // RUN cycle without stop: prescaler advances
  logic presc_zero;  // prescaler has expired (always true without it)
  logic start_clr;   // clear issued by a fresh start
  logic at_limit;

  logic cnt_count, cnt_clear, wrap, done;

  assign at_limit = (bus.q_i == bus.limit_i[WIDTH-1:0]);

  // Next-state logic and tick resolution; clear_i forces everything quiet.
  always_comb begin
    state_d   = state_q;
    tick      = 1'b0;
    reload    = 1'b0;
    run_adv   = 1'b0;
    start_clr = 1'b0;
    cnt_count = 1'b0;
    cnt_clear = 1'b0;
    wrap      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (!bus.stop_i && bus.start_i) begin
          start_clr = 1'b1;
          reload    = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.stop_i) begin
          state_d = ST_PAUSE;
        end else begin
          run_adv = 1'b1;
          tick    = presc_zero;
        end
      end
      ST_PAUSE: begin
        if (!bus.stop_i) begin
          if (bus.start_i) begin
            state_d = ST_RUN;
            reload  = 1'b1;
          end else if (bus.step_i) begin
            tick = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cnt_clear = start_clr;
    if (tick) begin
      if (!at_limit) begin
        cnt_count = 1'b1;
      end else if (!bus.mode_i) begin
        cnt_clear = 1'b1;
        wrap      = 1'b1;
      end else begin
        done    = 1'b1;
        state_d = ST_DONE;
      end
    end

    if (clear_i) begin
      state_d   = ST_IDLE;
      reload    = 1'b0;
      run_adv   = 1'b0;
      cnt_count = 1'b0;
      cnt_clear = 1'b0;
      wrap      = 1'b0;
      done      = 1'b0;
    end
  end

  // State register with synchronous clear.
  always_ff @(posedge clock_i) begin
    if (clear_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [PRESCALE_W-1:0] presc_q, presc_d;

  assign presc_zero = (presc_q == '0);

  // Prescaler: reload on start/resume and on every expiry, else count down.
  always_comb begin
    presc_d = presc_q;
    if (reload) begin
      presc_d = bus.prescale_i;
    end else if (run_adv) begin
      if (presc_zero) presc_d = bus.prescale_i;
      else            presc_d = presc_q - PRESCALE_W'(1);
    end
  end

  // Prescaler register with synchronous clear.
  always_ff @(posedge clock_i) begin
    if (clear_i) presc_q <= '0;
    else         presc_q <= presc_d;
  end
`else
  logic unused_prescale;

  assign presc_zero      = 1'b1;
  assign unused_prescale = ^{bus.prescale_i, reload, run_adv};
`endif

  assign bus.cnt_count_o = cnt_count;
  assign bus.cnt_clear_o = cnt_clear;
  assign bus.wrap_o      = wrap;
  assign bus.done_o      = done;
  assign bus.busy_o      = !clear_i && (state_q == ST_RUN);
  assign bus.state_o     = clear_i ? 2'd0 : state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed bench for counter_ctrl, with a behavioural
// 8-bit counter closing the loop on q_i.
module tb_counter_ctrl;

  logic clk;
  logic clear_i;

  counter_ctrl_if #(.WIDTH(8), .PRESCALE_W(16)) bus ();

  counter_ctrl #(.WIDTH(8), .PRESCALE_W(16)) dut (
    .clock_i (clk),
    .clear_i (clear_i),
    .bus     (bus)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Counter datapath: clear has priority; the board ORs clear_i in.
  logic [7:0] q;
  always_ff @(posedge clk) begin
    if (clear_i || bus.cnt_clear_o) q <= 8'd0;
    else if (bus.cnt_count_o)       q <= q + 8'd1;
  end
  assign bus.q_i = q;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [7:0] eq, input logic [1:0] es,
                         input logic ec, input logic ecl, input logic ew,
                         input logic ed, input logic eb);
    chk({nm, ".q"},     q,               eq);
    chk({nm, ".state"}, bus.state_o,     es);
    chk({nm, ".count"}, bus.cnt_count_o, ec);
    chk({nm, ".clear"}, bus.cnt_clear_o, ecl);
    chk({nm, ".wrap"},  bus.wrap_o,      ew);
    chk({nm, ".done"},  bus.done_o,      ed);
    chk({nm, ".busy"},  bus.busy_o,      eb);
  endtask

  // Move to the next cycle: drive point is just after the rising edge.
  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  typedef struct {
    logic       start, stop, step, mode;
    logic [7:0] limit;
    logic [7:0] eq;
    logic [1:0] es;
    logic       ec, ecl, ew, ed, eb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic sp, input logic se, input logic md,
                     input logic [7:0] lim, input logic [7:0] eq, input logic [1:0] es,
                     input logic ec, input logic ecl, input logic ew,
                     input logic ed, input logic eb);
    vec_t v;
    v.start = st; v.stop = sp; v.step = se; v.mode = md; v.limit = lim;
    v.eq = eq; v.es = es; v.ec = ec; v.ecl = ecl; v.ew = ew; v.ed = ed; v.eb = eb;
    vecs.push_back(v);
  endtask

  initial begin
    int k;
    clear_i        = 1'b1;
    bus.start_i    = 1'b1;
    bus.stop_i     = 1'b0;
    bus.step_i     = 1'b0;
    bus.mode_i     = 1'b0;
    bus.limit_i    = 8'd3;
    bus.prescale_i = 16'd0;

    // Reset: outputs forced low even with start_i high.
    to_drive();
    to_drive();
    to_sample();
    chk_all("reset", 8'd0, 2'd0, 0, 0, 0, 0, 0);

`ifdef COUNTER_CTRL_PRESCALE_EN
    // Prescale 2, limit 5, one-shot: ticks at 3,6,..,15, done at 18.
    for (int c = 0; c < 20; c++) begin
      to_drive();
      clear_i        = 1'b0;
      bus.start_i    = (c == 0);
      bus.mode_i     = 1'b1;
      bus.limit_i    = 8'd5;
      bus.prescale_i = 16'd2;
      to_sample();
      chk($sformatf("psc%0d.count", c), bus.cnt_count_o, (c >= 3 && c <= 15 && c % 3 == 0));
      chk($sformatf("psc%0d.done", c),  bus.done_o,      (c == 18));
      chk($sformatf("psc%0d.clear", c), bus.cnt_clear_o, (c == 0));
    end
    chk("psc.state", bus.state_o, 2'd3);
    chk("psc.q",     q,           8'd5);
    to_drive();
    bus.prescale_i = 16'd0;
    clear_i = 1'b1;
    to_drive();
    clear_i = 1'b0;
`endif

    // start,stop,step,mode,limit | q,state,count,clear,wrap,done,busy
    add(1,0,0,0,3,  0,0, 0,1,0,0,0);
    add(0,0,0,0,3,  0,1, 1,0,0,0,1);
    add(0,0,0,0,3,  1,1, 1,0,0,0,1);
    add(0,0,0,0,3,  2,1, 1,0,0,0,1);
    add(0,0,0,0,3,  3,1, 0,1,1,0,1);
    add(0,0,0,0,3,  0,1, 1,0,0,0,1);
    add(0,0,0,0,3,  1,1, 1,0,0,0,1);
    add(0,0,0,0,3,  2,1, 1,0,0,0,1);
    add(0,0,0,0,3,  3,1, 0,1,1,0,1);
    add(0,0,0,0,3,  0,1, 1,0,0,0,1);
    add(0,0,0,0,3,  1,1, 1,0,0,0,1);
    add(0,1,0,0,9,  2,1, 0,0,0,0,1);
    add(0,0,1,0,9,  2,2, 1,0,0,0,0);
    add(0,0,1,0,9,  3,2, 1,0,0,0,0);
    add(0,0,1,0,9,  4,2, 1,0,0,0,0);
    add(0,0,0,0,9,  5,2, 0,0,0,0,0);
    add(1,0,1,0,9,  5,2, 0,0,0,0,0);
    add(0,0,0,0,9,  5,1, 1,0,0,0,1);
    add(1,1,0,0,9,  6,1, 0,0,0,0,1);
    add(0,0,1,1,6,  6,2, 0,0,0,1,0);
    add(0,0,0,1,6,  6,3, 0,0,0,0,0);
    add(0,0,1,1,6,  6,3, 0,0,0,0,0);
    add(1,0,0,1,6,  6,3, 0,1,0,0,0);
    add(0,0,0,0,0,  0,1, 0,1,1,0,1);
    add(0,0,0,0,0,  0,1, 0,1,1,0,1);
    add(0,0,0,1,0,  0,1, 0,0,0,1,1);
    add(0,0,0,1,0,  0,3, 0,0,0,0,0);

    foreach (vecs[i]) begin
      to_drive();
      clear_i     = 1'b0;
      bus.start_i = vecs[i].start;
      bus.stop_i  = vecs[i].stop;
      bus.step_i  = vecs[i].step;
      bus.mode_i  = vecs[i].mode;
      bus.limit_i = vecs[i].limit;
      to_sample();
      chk_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].es, vecs[i].ec,
              vecs[i].ecl, vecs[i].ew, vecs[i].ed, vecs[i].eb);
    end

    // clear_i in the middle of a run, then restart from 0.
    to_drive();
    bus.start_i = 1'b1; bus.mode_i = 1'b0; bus.limit_i = 8'd100;
    to_drive();
    bus.start_i = 1'b0;
    to_drive(); to_drive(); to_drive();
    clear_i = 1'b1;
    to_sample();
    chk_all("clr_during", 8'd3, 2'd0, 0, 0, 0, 0, 0);
    to_drive();
    clear_i = 1'b0;
    to_sample();
    chk_all("clr_after", 8'd0, 2'd0, 0, 0, 0, 0, 0);
    to_drive();
    bus.start_i = 1'b1;
    to_sample();
    chk_all("clr_restart", 8'd0, 2'd0, 0, 1, 0, 0, 0);
    to_drive();
    bus.start_i = 1'b0;
    to_sample();
    chk_all("clr_run0", 8'd0, 2'd1, 1, 0, 0, 0, 1);
    to_drive();
    to_sample();
    chk_all("clr_run1", 8'd1, 2'd1, 1, 0, 0, 0, 1);

    // limit 255: wrap by explicit clear at q=255, 256 cycles after start.
    to_drive();
    clear_i = 1'b1;
    to_drive();
    clear_i = 1'b0; bus.start_i = 1'b1; bus.limit_i = 8'd255;
    to_drive();
    bus.start_i = 1'b0;
    to_sample();
    k = 1;
    while (q != 8'd255 && k < 300) begin
      to_drive(); to_sample(); k++;
    end
    chk("lim255.cycles", k, 256);
    chk_all("lim255.top", 8'd255, 2'd1, 0, 1, 1, 0, 1);
    to_drive(); to_sample();
    chk_all("lim255.zero", 8'd0, 2'd1, 1, 0, 0, 0, 1);

    // Lower the limit below q mid-run: natural overflow then wrap at 3.
    k = 0;
    while (q != 8'd5 && k < 20) begin
      to_drive(); to_sample(); k++;
    end
    chk("lower.reach5", q, 8'd5);
    bus.limit_i = 8'd3;
    k = 0;
    while (k < 300) begin
      to_drive(); to_sample(); k++;
      if (bus.wrap_o) break;
    end
    chk("lower.cycles", k, 254);
    chk("lower.q",      q, 8'd3);
    chk("lower.wrap",   bus.wrap_o, 1'b1);
    chk("lower.clear",  bus.cnt_clear_o, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
